// File: rtl/xilinx_sp_bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ requesters.
// Optional post-reset clear sweep; read data returned tagged to its issuer.
module xilinx_sp_bram_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int WE_WIDTH       = 4,
    parameter int DO_REG         = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    output logic [NUM_REQ-1:0]             REQ_READY,
    input  logic [NUM_REQ-1:0]             REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DI,
    output logic [NUM_REQ-1:0]             RSP_VALID,
    output logic [DATA_WIDTH-1:0]          RSP_DO,
    output logic                           BUSY,
    output logic                           BRAM_EN,
    output logic [7:0]                     BRAM_WE,
    output logic [14:0]                    BRAM_ADDR,
    output logic [DATA_WIDTH-1:0]          BRAM_DI,
    input  logic [DATA_WIDTH-1:0]          BRAM_DO,
    output logic                           BRAM_REGCE,
    output logic                           BRAM_RST
);

    localparam int RD_LAT = 1 + DO_REG;
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam logic [7:0] WE_MASK = 8'((16'd1 << WE_WIDTH) - 16'd1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_ARB
    } state_t;

    localparam state_t ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [NUM_REQ-1:0]      tag_sr [RD_LAT];

    logic                    arb_en;
    logic                    grant_vld;
    logic [PTR_W-1:0]        grant_idx;
    logic [NUM_REQ-1:0]      grant_oh;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_di;
    int                      scan;

    assign arb_en = !RST && (state == ST_ARB);

    // Rotating priority search starting at rr_ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (!grant_vld && REQ_VALID[scan]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(scan);
            end
        end
        if (!arb_en) begin
            grant_vld = 1'b0;
        end
    end

    assign grant_oh  = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    assign REQ_READY = grant_oh;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_di   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_we   = REQ_WE[i];
                sel_addr = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_di   = REQ_DI[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Clear sweep owns the port; otherwise the winner drives it directly
    always_comb begin
        BRAM_EN   = 1'b0;
        BRAM_WE   = '0;
        BRAM_ADDR = '0;
        BRAM_DI   = '0;
        if (!RST) begin
            if (state == ST_CLEAR) begin
                BRAM_EN   = 1'b1;
                BRAM_WE   = WE_MASK;
                BRAM_ADDR = 15'(clr_cnt);
                BRAM_DI   = CLEAR_VALUE;
            end else if (grant_vld) begin
                BRAM_EN   = 1'b1;
                BRAM_WE   = sel_we ? WE_MASK : 8'h00;
                BRAM_ADDR = 15'(sel_addr);
                BRAM_DI   = sel_di;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
            rr_ptr  <= '0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (grant_vld) begin
                        rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // One-hot tag pipeline matching BRAM read latency
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            tag_sr[0] <= (grant_vld && !sel_we) ? grant_oh : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign RSP_VALID  = tag_sr[RD_LAT-1];
    assign RSP_DO     = (|RSP_VALID) ? BRAM_DO : '0;
    assign BUSY       = RST || (state == ST_CLEAR);
    assign BRAM_REGCE = (DO_REG != 0);
    assign BRAM_RST   = 1'b0;

endmodule

// File: tb/tb_xilinx_sp_bram_arbiter.sv
// Directed bench for xilinx_sp_bram_arbiter with a behavioural BRAM
// (NUM_REQ=4, ADDR_WIDTH=4, DO_REG=1).
module tb_xilinx_sp_bram_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [31:0] CLR = 32'h1234_5678;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NR-1:0] REQ_VALID;
    logic [NR-1:0] REQ_READY;
    logic [NR-1:0] REQ_WE;
    logic [NR*AW-1:0] REQ_ADDR;
    logic [NR*DW-1:0] REQ_DI;
    logic [NR-1:0] RSP_VALID;
    logic [DW-1:0] RSP_DO;
    logic          BUSY;
    logic          BRAM_EN;
    logic [7:0]    BRAM_WE;
    logic [14:0]   BRAM_ADDR;
    logic [DW-1:0] BRAM_DI;
    logic [DW-1:0] BRAM_DO;
    logic          BRAM_REGCE;
    logic          BRAM_RST;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    xilinx_sp_bram_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WE_WIDTH(4),
        .DO_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_DI(REQ_DI),
        .RSP_VALID(RSP_VALID), .RSP_DO(RSP_DO), .BUSY(BUSY),
        .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
        .BRAM_DI(BRAM_DI), .BRAM_DO(BRAM_DO),
        .BRAM_REGCE(BRAM_REGCE), .BRAM_RST(BRAM_RST)
    );

    // Behavioural BRAM, write-first, with output register
    logic [DW-1:0] mem [16];
    logic [DW-1:0] dout;
    logic [DW-1:0] doreg;

    always @(posedge CLK) begin
        if (BRAM_EN) begin
            if (BRAM_WE[0]) begin
                mem[BRAM_ADDR[3:0]] <= BRAM_DI;
                dout <= BRAM_DI;
            end else begin
                dout <= mem[BRAM_ADDR[3:0]];
            end
        end
        if (BRAM_REGCE) doreg <= dout;
    end
    assign BRAM_DO = doreg;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        REQ_WE[i] = we;
        REQ_ADDR[i*AW +: AW] = a;
        REQ_DI[i*DW +: DW] = d;
    endtask

    task automatic clear_pass(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("clr_busy", 64'(BUSY), 64'd1);
            check("clr_addr", 64'(BRAM_ADDR), 64'(i));
            check("clr_en", 64'(BRAM_EN), 64'd1);
            check("clr_we", 64'(BRAM_WE), 64'h0F);
            check("clr_di", 64'(BRAM_DI), 64'(CLR));
            check("clr_ready", 64'(REQ_READY), 64'd0);
            check("clr_rsp", 64'(RSP_VALID), 64'd0);
            tick();
        end
    endtask

    initial begin
        RST = 1'b1;
        REQ_VALID = '1;
        REQ_WE = '0;
        REQ_ADDR = '0;
        REQ_DI = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", 64'(BUSY), 64'd1);
        check("rst_ready", 64'(REQ_READY), 64'd0);
        check("rst_rsp", 64'(RSP_VALID), 64'd0);
        check("rst_do", 64'(RSP_DO), 64'd0);
        check("rst_en", 64'(BRAM_EN), 64'd0);
        check("rst_we", 64'(BRAM_WE), 64'd0);
        check("regce", 64'(BRAM_REGCE), 64'd1);
        check("bram_rst", 64'(BRAM_RST), 64'd0);

        // Clear sweep after release, requesters held valid
        tick();
        RST = 1'b0;
        clear_pass(16);
        REQ_VALID = '0;
        @(negedge CLK);
        check("post_clr_busy", 64'(BUSY), 64'd0);
        check("idle_en", 64'(BRAM_EN), 64'd0);
        for (int i = 0; i < 16; i++) begin
            check("clr_mem", 64'(mem[i]), 64'(CLR));
        end

        // Write then read-after-write by req0
        tick();
        set_req(0, 1'b1, 4'd3, 32'hA5A5_A5A5);
        REQ_VALID = 4'b0001;
        @(negedge CLK);
        check("wr_ready", 64'(REQ_READY), 64'b0001);
        check("wr_en", 64'(BRAM_EN), 64'd1);
        check("wr_we", 64'(BRAM_WE), 64'h0F);
        check("wr_addr", 64'(BRAM_ADDR), 64'd3);
        check("wr_di", 64'(BRAM_DI), 64'hA5A5_A5A5);
        tick();
        set_req(0, 1'b0, 4'd3, 32'h0);
        @(negedge CLK);
        check("rd_ready", 64'(REQ_READY), 64'b0001);
        check("rd_we", 64'(BRAM_WE), 64'd0);
        check("wr_rsp", 64'(RSP_VALID), 64'd0);
        tick();
        REQ_VALID = '0;
        @(negedge CLK);
        check("rd_lat1", 64'(RSP_VALID), 64'd0);
        tick();
        @(negedge CLK);
        check("rd_lat2", 64'(RSP_VALID), 64'b0001);
        check("rd_data", 64'(RSP_DO), 64'hA5A5_A5A5);
        tick();
        @(negedge CLK);
        check("rd_strobe", 64'(RSP_VALID), 64'd0);

        // Writes from req2/req3 leave the pointer at 0
        tick();
        set_req(2, 1'b1, 4'd1, 32'hB0B0_0001);
        set_req(3, 1'b1, 4'd2, 32'hB0B0_0002);
        REQ_VALID = 4'b1100;
        @(negedge CLK);
        check("w2_ready", 64'(REQ_READY), 64'b0100);
        tick();
        @(negedge CLK);
        check("w3_ready", 64'(REQ_READY), 64'b1000);
        tick();
        REQ_VALID = '0;
        REQ_WE = '0;

        // req0 and req1 contend for six cycles
        set_req(0, 1'b0, 4'd1, 32'h0);
        set_req(1, 1'b0, 4'd2, 32'h0);
        for (int k = 0; k < 8; k++) begin
            REQ_VALID = (k < 6) ? 4'b0011 : 4'b0000;
            @(negedge CLK);
            if (k < 6) begin
                check("rr_ready", 64'(REQ_READY),
                      (k % 2 == 0) ? 64'b0001 : 64'b0010);
                check("rr_addr", 64'(BRAM_ADDR),
                      (k % 2 == 0) ? 64'd1 : 64'd2);
            end
            if (k >= 2) begin
                check("rr_rsp", 64'(RSP_VALID),
                      (k % 2 == 0) ? 64'b0001 : 64'b0010);
                check("rr_do", 64'(RSP_DO),
                      (k % 2 == 0) ? 64'hB0B0_0001 : 64'hB0B0_0002);
            end else begin
                check("rr_rsp0", 64'(RSP_VALID), 64'd0);
            end
            tick();
        end

        // Only req2/req3 active, pointer starts at 2
        set_req(2, 1'b0, 4'd4, 32'h0);
        set_req(3, 1'b0, 4'd4, 32'h0);
        for (int k = 0; k < 4; k++) begin
            REQ_VALID = 4'b1100;
            @(negedge CLK);
            check("hi_ready", 64'(REQ_READY),
                  (k % 2 == 0) ? 64'b0100 : 64'b1000);
            tick();
        end
        REQ_VALID = '0;
        tick();
        tick();

        // Reset one cycle after a read grant
        set_req(1, 1'b0, 4'd3, 32'h0);
        REQ_VALID = 4'b0010;
        @(negedge CLK);
        check("pre_rst_ready", 64'(REQ_READY), 64'b0010);
        tick();
        REQ_VALID = '1;
        RST = 1'b1;
        @(negedge CLK);
        check("inrst_rsp", 64'(RSP_VALID), 64'd0);
        check("inrst_busy", 64'(BUSY), 64'd1);
        check("inrst_en", 64'(BRAM_EN), 64'd0);
        check("inrst_ready", 64'(REQ_READY), 64'd0);
        tick();
        RST = 1'b0;
        clear_pass(7);

        // Reset pulse mid-sweep at clr_cnt=7
        @(negedge CLK);
        check("mid_addr", 64'(BRAM_ADDR), 64'd7);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        clear_pass(16);
        set_req(0, 1'b0, 4'd3, 32'h0);
        @(negedge CLK);
        check("end_busy", 64'(BUSY), 64'd0);
        check("ptr_reset", 64'(REQ_READY), 64'b0001);
        tick();
        REQ_VALID = '0;
        tick();
        @(negedge CLK);
        check("reclr_rsp", 64'(RSP_VALID), 64'b0001);
        check("reclr_do", 64'(RSP_DO), 64'(CLR));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
